// File: rtl/aes_iter_encrypt.sv
// Iterative AES encryptor: one round per clock, on-the-fly key schedule.
// KEY_BITS selects AES-128 (10 rounds) or AES-256 (14 rounds).
module aes_iter_encrypt #(
   parameter int KEY_BITS = 128
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [127:0]        in_data,
   input  logic [KEY_BITS-1:0] in_key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        out_data,
   output logic                busy
);

   localparam int NR = (KEY_BITS == 256) ? 14 : 10;

   generate
      if (KEY_BITS != 128 && KEY_BITS != 256) begin : g_bad_key
         $error("aes_iter_encrypt: KEY_BITS must be 128 or 256");
      end
   endgenerate

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] subword(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // Byte i of the block sits at s[127-8i -: 8]; column c holds bytes 4c..4c+3.
   function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk,
                                              input logic last);
      logic [7:0]   b [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      logic [127:0] r;
      for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
      for (int c = 0; c < 4; c++)
         for (int w = 0; w < 4; w++) t[4*c+w] = b[4*((c+w)%4)+w];
      for (int c = 0; c < 4; c++) begin
         m[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
         m[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
         m[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
         m[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
      end
      r = '0;
      for (int i = 0; i < 16; i++) r[127-8*i -: 8] = last ? t[i] : m[i];
      return r ^ rk;
   endfunction

   typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;
   fsm_t fsm, fsm_nxt;

   logic [127:0]        state;
   logic [KEY_BITS-1:0] kwin, kwin_nxt;
   logic [3:0]          rnd;
   logic [7:0]          rcon;
   logic [127:0]        rk, newk, rres;
   logic [31:0]         w0, w1, w2, w3, temp, n0, n1, n2, n3;
   logic                use_rcon, last;

   assign last     = (rnd == 4'(NR));
   // AES-256 alternates RotWord+SubWord+Rcon (odd rounds) with SubWord only.
   assign use_rcon = (KEY_BITS == 128) || rnd[0];
   assign {w0, w1, w2, w3} = kwin[KEY_BITS-1 -: 128];
   assign temp = use_rcon ? (subword({kwin[23:0], kwin[31:24]}) ^ {rcon, 24'h0})
                          : subword(kwin[31:0]);
   assign n0   = w0 ^ temp;
   assign n1   = w1 ^ n0;
   assign n2   = w2 ^ n1;
   assign n3   = w3 ^ n2;
   assign newk = {n0, n1, n2, n3};

   generate
      if (KEY_BITS == 256) begin : g_k256
         assign rk       = kwin[127:0];
         assign kwin_nxt = {kwin[127:0], newk};
      end else begin : g_k128
         assign rk       = newk;
         assign kwin_nxt = newk;
      end
   endgenerate

   assign rres = aes_round(state, rk, last);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) fsm <= IDLE;
      else       fsm <= fsm_nxt;
   end

   always_comb begin
      fsm_nxt = fsm;
      case (fsm)
         IDLE:    if (in_valid)  fsm_nxt = ROUND;
         ROUND:   if (last)      fsm_nxt = DONE;
         DONE:    if (out_ready) fsm_nxt = IDLE;
         default:                fsm_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= '0;
         kwin     <= '0;
         rnd      <= '0;
         rcon     <= '0;
         out_data <= '0;
      end else begin
         case (fsm)
            IDLE: if (in_valid) begin
               state <= in_data ^ in_key[KEY_BITS-1 -: 128];
               kwin  <= in_key;
               rnd   <= 4'd1;
               rcon  <= 8'h01;
            end
            ROUND: begin
               state <= rres;
               kwin  <= kwin_nxt;
               rnd   <= rnd + 4'd1;
               if (use_rcon) rcon <= xt(rcon);
               if (last) out_data <= rres;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (fsm == IDLE);
   assign out_valid = (fsm == DONE);
   assign busy      = (fsm != IDLE);

endmodule

// File: tb/tb_aes_iter_encrypt.sv
// Directed bench for aes_iter_encrypt: FIPS-197 vectors on a 128-bit and a 256-bit instance.
module tb_aes_iter_encrypt;

   logic         clk = 1'b0;
   logic         reset;
   logic         iv [2];
   logic         ir [2];
   logic         ov [2];
   logic         ordy [2];
   logic         bsy [2];
   logic [127:0] id [2];
   logic [127:0] od [2];
   logic [127:0] ka;
   logic [255:0] kb;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_iter_encrypt #(.KEY_BITS(128)) dut128 (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
      .in_key(ka), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]), .busy(bsy[0]));

   aes_iter_encrypt #(.KEY_BITS(256)) dut256 (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
      .in_key(kb), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]), .busy(bsy[1]));

   typedef struct {
      logic [255:0] key;   // AES-128 keys are left-aligned
      logic [127:0] pt;
      logic [127:0] ct;
      int           sel;   // 0: 128-bit instance, 1: 256-bit instance
      bit           disturb;
      int           hold;  // cycles of out_ready=0 after out_valid
   } vec_t;

   vec_t vt [6];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      id[v.sel] = v.pt;
      if (v.sel == 0) ka = v.key[255:128];
      else            kb = v.key;
   endtask

   // Called just after the accept edge's negedge; counts edges until out_valid.
   task automatic wait_ov(input int s, input bit disturb, output int lat);
      lat = 0;
      while (!ov[s] && lat < 40) begin
         @(posedge clk); lat++;
         @(negedge clk);
         if (disturb && !ov[s]) begin
            id[s] = {$urandom, $urandom, $urandom, $urandom};
            ka    = {$urandom, $urandom, $urandom, $urandom};
            kb    = {ka, $urandom, $urandom, $urandom, $urandom};
            iv[s] = ~iv[s];
         end
      end
      iv[s] = 1'b0;
      if (!ov[s]) chk("out_valid_timeout", 0, 1);
   endtask

   task automatic run_vec(input vec_t v);
      int s, lat, n;
      s = v.sel;
      load(v);
      ordy[s] = (v.hold == 0);
      iv[s]   = 1'b1;
      n = 0;
      while (!ir[s] && n < 50) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      iv[s] = 1'b0;
      wait_ov(s, v.disturb, lat);
      chk("latency", lat, (s == 1) ? 14 : 10);
      chk("ciphertext", od[s], v.ct);
      chk("in_ready_done", ir[s], 0);
      chk("busy_done", bsy[s], 1);
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); @(negedge clk);
         chk("bp_out_valid", ov[s], 1);
         chk("bp_out_data", od[s], v.ct);
         chk("bp_in_ready", ir[s], 0);
      end
      ordy[s] = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("post_out_valid", ov[s], 0);
      chk("post_in_ready", ir[s], 1);
      chk("post_busy", bsy[s], 0);
      chk("post_out_data_kept", od[s], v.ct);
   endtask

   initial begin
      int lat;
      vt[0] = '{{128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0, 1'b0, 0};
      vt[1] = '{{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32, 0, 1'b0, 0};
      vt[2] = '{256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089, 1, 1'b0, 0};
      vt[3] = vt[1]; vt[3].disturb = 1'b1;
      vt[4] = vt[2]; vt[4].disturb = 1'b1;
      vt[5] = vt[2]; vt[5].hold = 20;

      reset = 1'b1;
      for (int s = 0; s < 2; s++) begin
         iv[s] = 1'b0; ordy[s] = 1'b1; id[s] = '0;
      end
      ka = '0; kb = '0;
      #1;
      for (int s = 0; s < 2; s++) begin
         chk("rst_in_ready", ir[s], 1);
         chk("rst_out_valid", ov[s], 0);
         chk("rst_busy", bsy[s], 0);
         chk("rst_out_data", od[s], 0);
      end
      @(negedge clk); @(negedge clk);
      reset = 1'b0;

      foreach (vt[i]) run_vec(vt[i]);

      // Back-to-back: second block held on the input through the first one's flight.
      load(vt[0]); iv[0] = 1'b1; ordy[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      load(vt[1]);
      wait_ov(0, 1'b0, lat);
      iv[0] = 1'b1;
      chk("b2b_lat0", lat, 10);
      chk("b2b_ct0", od[0], vt[0].ct);
      chk("b2b_in_ready_done", ir[0], 0);
      @(posedge clk); @(negedge clk);
      chk("b2b_idle_in_ready", ir[0], 1);
      chk("b2b_idle_out_valid", ov[0], 0);
      @(posedge clk); @(negedge clk);
      chk("b2b_second_accept", bsy[0], 1);
      iv[0] = 1'b0;
      wait_ov(0, 1'b0, lat);
      chk("b2b_lat1", lat, 10);
      chk("b2b_ct1", od[0], vt[1].ct);
      @(posedge clk); @(negedge clk);

      // Reset in the middle of round 5.
      load(vt[0]); iv[0] = 1'b1;
      @(posedge clk); @(negedge clk);
      iv[0] = 1'b0;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_out_valid", ov[0], 0);
      chk("midrst_busy", bsy[0], 0);
      chk("midrst_in_ready", ir[0], 1);
      chk("midrst_out_data", od[0], 0);
      @(negedge clk);
      reset = 1'b0;
      run_vec(vt[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
